// File: rtl/fifo_serial_tx_pkg.sv
// Shared definitions for the FIFO-side serial transmitter: state encodings,
// data width and timer width.
package fifo_serial_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned BIT_IDX_W = 3;
  localparam int unsigned TIMER_W   = 8;

  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

endpackage

// File: rtl/fifo_serial_tx_bit_timer.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 and wraps, TICK marks the last
// cycle of each bit period. CLR holds/forces the count to zero.
module bit_timer
  import fifo_serial_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic CLK,
  input  logic RESET,
  input  logic CLR,
  output logic TICK
);

  localparam logic [TIMER_W-1:0] LAST_CNT = TIMER_W'(CLKS_PER_BIT - 1);

  logic [TIMER_W-1:0] cnt_q;
  logic [TIMER_W-1:0] cnt_d;

  assign TICK = (cnt_q == LAST_CNT);

  // Next count: wrap after the last cycle of a bit, or clear on request.
  always_comb begin
    cnt_d = cnt_q + TIMER_W'(1);
    if (CLR || TICK) begin
      cnt_d = '0;
    end
  end

  // Count register with asynchronous clear.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_serial_tx.sv
// 8N1 serial transmitter fed directly from a 16x8 FIFO. One word is read per
// frame; frames run back to back with a single IDLE cycle while data remains.
module fifo_serial_tx
  import fifo_serial_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 EN,
  input  logic [DATA_BITS-1:0] FIFO_DOUT,
  input  logic                 FIFO_EF,
  output logic                 FIFO_RE,
  output logic                 TXD,
  output logic                 BUSY,
  output logic                 FRAME_DONE
);

  tx_state_e              state_q;
  logic [DATA_BITS-1:0]   shreg_q;
  logic [BIT_IDX_W-1:0]   bit_idx_q;
  logic                   txd_q;
  logic                   busy_q;
  logic                   tick;
  logic                   tmr_clr;

  // The read strobe has to be combinational so the FIFO advances on the same
  // edge that captures its head word; RESET gates it while the FSM is held.
  assign FIFO_RE    = (state_q == IDLE) && EN && !FIFO_EF && !RESET;
  assign FRAME_DONE = (state_q == STOP) && tick;
  assign TXD        = txd_q;
  assign BUSY       = busy_q;

  // Holding the timer cleared through IDLE makes START begin at count 0;
  // every other state exit happens on TICK, where the counter wraps to 0.
  assign tmr_clr = (state_q == IDLE);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .CLK  (CLK),
    .RESET(RESET),
    .CLR  (tmr_clr),
    .TICK (tick)
  );

  // Frame sequencer: TXD is loaded one edge ahead so the line is registered.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (FIFO_RE) begin
            shreg_q   <= FIFO_DOUT;
            bit_idx_q <= '0;
            txd_q     <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= START;
          end
        end
        START: begin
          if (tick) begin
            txd_q   <= shreg_q[0];
            state_q <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx_q == LAST_BIT) begin
              txd_q   <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + BIT_IDX_W'(1);
              shreg_q   <= shreg_q >> 1;
              txd_q     <= shreg_q[1];
            end
          end
        end
        STOP: begin
          if (tick) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
